// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: round-robin arbiter sharing one data-memory port among NUM_REQ requesters.
// One access in flight at a time: IDLE (grant) -> ISSUE (memory op) -> DONE (response).
module dmem_rr_arbiter #(
  parameter int NUM_REQ = 16,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_ctrl,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [1:0]                 mem_ctrl,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] ptr, id, win, idx;
  logic [1:0] op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic found, mem_op;
  logic [1:0] ctrl_a [NUM_REQ];
  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ctrl_a[g]  = req_ctrl[2*g +: 2];
    assign addr_a[g]  = req_addr[ADDR_W*g +: ADDR_W];
    assign wdata_a[g] = req_wdata[DATA_W*g +: DATA_W];
  end
  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (found ? ISSUE : IDLE) : state == ISSUE ? DONE : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      id <= '0;
      op <= 2'b00;
      addr <= '0;
      wdata <= '0;
    end else if (state == IDLE && found) begin
      ptr <= win == ID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
      id <= win;
      op <= ctrl_a[win];
      addr <= addr_a[win];
      wdata <= wdata_a[win];
    end
  end
  // Ops 00/01 have no memory counterpart; they complete with rsp_err instead.
  always_comb begin
    mem_op = state == ISSUE && op[1];
    busy = state != IDLE;
    req_ready = (reset_n && state == IDLE && found) ? NUM_REQ'(1) << win : '0;
    rsp_valid = state == DONE ? NUM_REQ'(1) << id : '0;
    rsp_err = state == DONE && !op[1];
    rsp_rdata = (state == DONE && op == 2'b10) ? mem_rdata : '0;
    mem_ctrl = mem_op ? op : 2'b00;
    mem_addr = mem_op ? addr : '0;
    mem_wdata = mem_op ? wdata : '0;
    grant_id = busy ? id : '0;
  end
endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// tb_dmem_rr_arbiter: directed checks of grant order, memory timing, errors and reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_dmem_rr_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] req_valid = '0;
  logic [31:0] req_ctrl = '0;
  logic [255:0] req_addr = '0;
  logic [255:0] req_wdata = '0;
  logic [15:0] req_ready, rsp_valid;
  logic rsp_err, busy;
  logic [15:0] rsp_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [1:0] mem_ctrl;
  logic [3:0] grant_id;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] mem [256];
  bit written [256];

  dmem_rr_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ctrl(req_ctrl),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  // Registered memory; unwritten words read back as 16'h1000 + address.
  always @(posedge clock) begin
    if (mem_ctrl == 2'b11) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    mem_rdata <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : 16'h1000 + {8'h00, mem_addr[7:0]};
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    req_valid[i] = 1'b1;
    req_ctrl[2*i +: 2] = op;
    req_addr[16*i +: 16] = a;
    req_wdata[16*i +: 16] = d;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = 16'h0001;
    #1;
    n_checks++; if (req_ready !== 16'h0) begin n_fail++; $display("FAIL rst_ready: got %h want 0000", req_ready); end
    n_checks++; if (mem_ctrl !== 2'b00) begin n_fail++; $display("FAIL rst_mem_ctrl: got %b want 00", mem_ctrl); end
    n_checks++; if (busy !== 1'b0 || grant_id !== 4'd0) begin n_fail++; $display("FAIL rst_busy_id: got %b/%0d want 0/0", busy, grant_id); end
    n_checks++; if (rsp_valid !== 16'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got %h/%b want 0000/0", rsp_valid, rsp_err); end
    req_valid = '0;
    reset_dut();
  endtask

  task automatic test_fairness();
    int w;
    for (int i = 0; i < 16; i++) set_req(i, 2'b10, 16'(i), 16'h0);
    reset_dut();
    for (int g = 0; g < 17; g++) begin
      w = g % 16;
      n_checks++; if (req_ready !== 16'(1 << w)) begin n_fail++; $display("FAIL rr_ready[%0d]: got %h want %h", g, req_ready, 16'(1 << w)); end
      step();
      n_checks++; if (mem_ctrl !== 2'b10 || mem_addr !== 16'(w) || grant_id !== 4'(w)) begin n_fail++; $display("FAIL rr_issue[%0d]: got ctrl %b addr %h id %0d want 10 %h %0d", g, mem_ctrl, mem_addr, grant_id, w, w); end
      step();
      n_checks++; if (rsp_valid !== 16'(1 << w) || rsp_err !== 1'b0 || rsp_rdata !== 16'h1000 + 16'(w)) begin n_fail++; $display("FAIL rr_done[%0d]: got %h err %b data %h want %h 0 %h", g, rsp_valid, rsp_err, rsp_rdata, 16'(1 << w), 16'h1000 + 16'(w)); end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_write_read();
    set_req(3, 2'b11, 16'd5, 16'hBEEF);
    #1;
    n_checks++; if (req_ready !== 16'h0008) begin n_fail++; $display("FAIL wr_ready: got %h want 0008", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_checks++; if (mem_ctrl !== 2'b11 || mem_addr !== 16'd5 || mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_issue: got %b %h %h want 11 0005 beef", mem_ctrl, mem_addr, mem_wdata); end
    n_checks++; if (req_ready !== 16'h0 || busy !== 1'b1 || grant_id !== 4'd3) begin n_fail++; $display("FAIL wr_busy: got ready %h busy %b id %0d want 0000 1 3", req_ready, busy, grant_id); end
    step();
    n_checks++; if (rsp_valid !== 16'h0008 || rsp_err !== 1'b0 || mem_ctrl !== 2'b00 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL wr_done: got %h err %b ctrl %b addr %h want 0008 0 00 0000", rsp_valid, rsp_err, mem_ctrl, mem_addr); end
    step();
    set_req(3, 2'b10, 16'd5, 16'h0);
    #1;
    n_checks++; if (req_ready !== 16'h0008) begin n_fail++; $display("FAIL rd_ready: got %h want 0008", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_checks++; if (mem_ctrl !== 2'b10 || mem_addr !== 16'd5) begin n_fail++; $display("FAIL rd_issue: got %b %h want 10 0005", mem_ctrl, mem_addr); end
    step();
    n_checks++; if (rsp_valid !== 16'h0008 || rsp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_done: got %h data %h want 0008 beef", rsp_valid, rsp_rdata); end
    step();
  endtask

  task automatic test_wrap();
    reset_dut();
    set_req(13, 2'b10, 16'd13, 16'h0);
    #1;
    n_checks++; if (req_ready !== 16'h2000) begin n_fail++; $display("FAIL wrap_pre: got %h want 2000", req_ready); end
    step();
    req_valid = '0;
    repeat (2) step();
    set_req(0, 2'b10, 16'd0, 16'h0);
    set_req(1, 2'b10, 16'd1, 16'h0);
    set_req(14, 2'b10, 16'd14, 16'h0);
    #1;
    n_checks++; if (req_ready !== 16'h4000) begin n_fail++; $display("FAIL wrap_14: got %h want 4000", req_ready); end
    step();
    req_valid[14] = 1'b0;
    set_req(15, 2'b10, 16'd15, 16'h0);
    repeat (2) step();
    n_checks++; if (req_ready !== 16'h8000) begin n_fail++; $display("FAIL wrap_15: got %h want 8000", req_ready); end
    step();
    req_valid[15] = 1'b0;
    repeat (2) step();
    n_checks++; if (req_ready !== 16'h0001) begin n_fail++; $display("FAIL wrap_0: got %h want 0001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    repeat (2) step();
    n_checks++; if (req_ready !== 16'h0002) begin n_fail++; $display("FAIL wrap_1: got %h want 0002", req_ready); end
    step();
    req_valid[1] = 1'b0;
    repeat (2) step();
    n_checks++; if (req_ready !== 16'h0000 || busy !== 1'b0) begin n_fail++; $display("FAIL wrap_end: got %h busy %b want 0000 0", req_ready, busy); end
  endtask

  task automatic test_unsupported();
    set_req(7, 2'b01, 16'd33, 16'h5555);
    #1;
    n_checks++; if (req_ready !== 16'h0080) begin n_fail++; $display("FAIL unsup_ready: got %h want 0080", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_checks++; if (mem_ctrl !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL unsup_issue: got ctrl %b busy %b want 00 1", mem_ctrl, busy); end
    step();
    n_checks++; if (rsp_valid !== 16'h0080 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0 || mem_ctrl !== 2'b00) begin n_fail++; $display("FAIL unsup_done: got %h err %b data %h ctrl %b want 0080 1 0000 00", rsp_valid, rsp_err, rsp_rdata, mem_ctrl); end
    step();
  endtask

  task automatic test_reset_during_issue();
    set_req(2, 2'b11, 16'd9, 16'h1234);
    step();
    req_valid = '0;
    #1;
    n_checks++; if (mem_ctrl !== 2'b11) begin n_fail++; $display("FAIL rdi_issue: got %b want 11", mem_ctrl); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (mem_ctrl !== 2'b00 || busy !== 1'b0 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL rdi_async: got ctrl %b busy %b addr %h want 00 0 0000", mem_ctrl, busy, mem_addr); end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 16'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rdi_norsp: got %h busy %b want 0000 0", rsp_valid, busy); end
    set_req(0, 2'b10, 16'd9, 16'h0);
    set_req(5, 2'b10, 16'd5, 16'h0);
    #1;
    n_checks++; if (req_ready !== 16'h0001) begin n_fail++; $display("FAIL rdi_first: got %h want 0001", req_ready); end
    step();
    req_valid = '0;
    repeat (1) step();
    n_checks++; if (rsp_valid !== 16'h0001 || rsp_rdata !== 16'h1009) begin n_fail++; $display("FAIL rdi_nowrite: got %h data %h want 0001 1009", rsp_valid, rsp_rdata); end
    step();
  endtask

  task automatic test_drop_valid();
    set_req(2, 2'b10, 16'd2, 16'h0);
    set_req(4, 2'b11, 16'd44, 16'hDEAD);
    #1;
    n_checks++; if (req_ready !== 16'h0004) begin n_fail++; $display("FAIL drop_first: got %h want 0004", req_ready); end
    step();
    req_valid = '0;
    repeat (2) step();
    n_checks++; if (req_ready !== 16'h0 || busy !== 1'b0 || mem_ctrl !== 2'b00) begin n_fail++; $display("FAIL drop_gap: got %h busy %b ctrl %b want 0000 0 00", req_ready, busy, mem_ctrl); end
    step();
    set_req(6, 2'b10, 16'd6, 16'h0);
    #1;
    n_checks++; if (req_ready !== 16'h0040) begin n_fail++; $display("FAIL drop_next: got %h want 0040", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_checks++; if (mem_ctrl !== 2'b10 || mem_addr !== 16'd6) begin n_fail++; $display("FAIL drop_issue: got %b %h want 10 0006", mem_ctrl, mem_addr); end
    step();
    n_checks++; if (rsp_valid !== 16'h0040) begin n_fail++; $display("FAIL drop_done: got %h want 0040", rsp_valid); end
    step();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_write_read();
    test_wrap();
    test_unsupported();
    test_reset_during_issue();
    test_drop_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
